// File: rtl/sop_pkg.sv
// Shared types and geometry for the sum-of-products cube evaluator.
// A cube is a product term over N_VARS literals with a per-cube enable.
package sop_pkg;

  localparam int N_VARS  = 11;
  localparam int N_CUBES = 64;
  localparam int LANES   = 4;

  localparam int IDX_W  = $clog2(N_CUBES);
  localparam int GRP_N  = N_CUBES / LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam bit GEOMETRY_OK = (LANES >= 1) && (LANES <= N_CUBES) &&
                               ((N_CUBES % LANES) == 0);

  typedef struct packed {
    logic [N_VARS-1:0] care;
    logic [N_VARS-1:0] val;
    logic              en;
  } cube_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // A cube with no cared-for literals is the constant-1 term.
  function automatic logic cube_hit(input cube_t c, input logic [N_VARS-1:0] v);
    return c.en && (((v ^ c.val) & c.care) == '0);
  endfunction

endpackage

// File: rtl/sop_cube_match.sv
// Compares one group of LANES cubes against a vector and reports whether any
// matched plus the lowest matching lane.
module sop_cube_match
  import sop_pkg::*;
(
  input  cube_t             cubes_i [LANES],
  input  logic [N_VARS-1:0] vec_i,
  output logic              any_hit_o,
  output logic [LANE_W-1:0] offset_o
);

  // Walk from the highest lane down so the lowest matching lane wins.
  always_comb begin
    any_hit_o = 1'b0;
    offset_o  = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (cube_hit(cubes_i[l], vec_i)) begin
        any_hit_o = 1'b1;
        offset_o  = LANE_W'(l);
      end
    end
  end

endmodule

// File: rtl/sop_cube_evaluator.sv
// Programmable SOP evaluator: holds the cube table, scans it LANES cubes per
// cycle for one latched vector and returns F plus the first matching cube index.
module sop_cube_evaluator
  import sop_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [N_VARS-1:0] cfg_care,
  input  logic [N_VARS-1:0] cfg_val,
  input  logic              cfg_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_VARS-1:0] in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_f,
  output logic [IDX_W-1:0]  out_hit_idx
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'((GRP_N - 1) * LANES);
  localparam logic [IDX_W-1:0] PTR_STEP = IDX_W'(LANES);

  if (!GEOMETRY_OK) begin : g_geometry_check
    $error("sop_cube_evaluator: N_CUBES must be a multiple of LANES");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_VARS-1:0] vec_q, vec_d;
  logic              f_q, f_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;

  cube_t             table_q [N_CUBES];
  cube_t             grp [LANES];
  logic              grp_hit;
  logic [LANE_W-1:0] grp_off;

  assign cfg_ready   = (state_q == IDLE);
  assign in_ready    = (state_q == IDLE) && !cfg_we;
  assign out_valid   = valid_q;
  assign out_f       = f_q;
  assign out_hit_idx = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CUBES; i++) table_q[i] <= '0;
    end else if (cfg_we && cfg_ready) begin
      table_q[cfg_addr] <= {cfg_care, cfg_val, cfg_en};
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_group
    assign grp[l] = table_q[ptr_q + IDX_W'(l)];
  end

  sop_cube_match u_match (
    .cubes_i   (grp),
    .vec_i     (vec_q),
    .any_hit_o (grp_hit),
    .offset_o  (grp_off)
  );

  // DONE spends one cycle registering out_valid before presenting the result,
  // so a group-g hit appears g+2 cycles after the accepting edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    vec_d   = vec_q;
    f_d     = f_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = SCAN;
          ptr_d   = '0;
          vec_d   = in_vec;
        end
      end
      SCAN: begin
        if (grp_hit) begin
          state_d = DONE;
          f_d     = 1'b1;
          idx_d   = ptr_q + IDX_W'(grp_off);
        end else if (ptr_q == LAST_PTR) begin
          state_d = DONE;
          f_d     = 1'b0;
          idx_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_STEP;
        end
      end
      DONE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      vec_q   <= '0;
      f_q     <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vec_q   <= vec_d;
      f_q     <= f_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_sop_cube_evaluator.sv
// Self-checking bench for sop_cube_evaluator: directed corner cases with literal
// expectations plus randomized tables/vectors against a first-match table model.
module tb_sop_cube_evaluator;

  localparam int NV = 11;
  localparam int NC = 64;
  localparam int NL = 4;
  localparam int MISS_LAT = NC / NL + 1;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic          cfg_ready;
  logic [5:0]    cfg_addr;
  logic [NV-1:0] cfg_care;
  logic [NV-1:0] cfg_val;
  logic          cfg_en;
  logic          in_valid;
  logic          in_ready;
  logic [NV-1:0] in_vec;
  logic          out_valid;
  logic          out_ready;
  logic          out_f;
  logic [5:0]    out_hit_idx;

  logic [NV-1:0] mCare [NC];
  logic [NV-1:0] mVal  [NC];
  logic          mEn   [NC];

  int            total = 0;
  int            bad = 0;
  logic          expArmed = 1'b0;
  logic          expF = 1'b0;
  logic [5:0]    expIdx = '0;
  logic          lastF;
  logic [5:0]    lastIdx;
  int            lastLat;

  sop_cube_evaluator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_care    (cfg_care),
    .cfg_val     (cfg_val),
    .cfg_en      (cfg_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_f       (out_f),
    .out_hit_idx (out_hit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the lowest-indexed enabled cube whose cared literals agree wins.
  function automatic void modelEval(input logic [NV-1:0] v, output logic f,
                                    output logic [5:0] idx, output int lat);
    f   = 1'b0;
    idx = '0;
    lat = MISS_LAT;
    for (int i = NC - 1; i >= 0; i--) begin
      if (mEn[i] && (((v ^ mVal[i]) & mCare[i]) == '0)) begin
        f   = 1'b1;
        idx = 6'(i);
        lat = i / NL + 2;
      end
    end
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < NC; i++) begin
      mCare[i] = '0;
      mVal[i]  = '0;
      mEn[i]   = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && expArmed) begin
      checkOutput("out_f", 32'(out_f), 32'(expF));
      checkOutput("out_hit_idx", 32'(out_hit_idx), 32'(expIdx));
    end
  end

  task automatic writeCube(input int addr, input logic [NV-1:0] care,
                           input logic [NV-1:0] val, input logic en);
    int waitCnt;
    @(negedge clk);
    waitCnt = 0;
    while (!cfg_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cfg_ready) begin
      checkOutput("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
      return;
    end
    cfg_we   = 1'b1;
    cfg_addr = 6'(addr);
    cfg_care = care;
    cfg_val  = val;
    cfg_en   = en;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    mCare[addr] = care;
    mVal[addr]  = val;
    mEn[addr]   = en;
  endtask

  // One transaction; hold>0 keeps out_ready low that many valid cycles while
  // attempting a (to-be-dropped) config write to cube 0.
  task automatic applyStimulus(input logic [NV-1:0] vec, input int hold);
    int waitCnt;
    int lat;
    int expLat;
    logic ef;
    logic [5:0] ei;
    @(negedge clk);
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    modelEval(vec, ef, ei, expLat);
    expF      = ef;
    expIdx    = ei;
    in_vec    = vec;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    expArmed = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    lastLat = lat;
    lastF   = out_f;
    lastIdx = out_hit_idx;
    checkOutput("latency", 32'(lat), 32'(expLat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_care = '1;
      cfg_val  = '1;
      cfg_en   = 1'b1;
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_cfg_ready", 32'(cfg_ready), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      cfg_we    = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1 expArmed = 1'b0;
    @(negedge clk);
    checkOutput("valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_care  = '0;
    cfg_val   = '0;
    cfg_en    = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    modelClear();

    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_f", 32'(out_f), 32'd0);
    checkOutput("rst_hit_idx", 32'(out_hit_idx), 32'd0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;

    applyStimulus(11'h000, 0);
    checkOutput("lit_empty_f", 32'(lastF), 32'd0);
    checkOutput("lit_empty_lat", 32'(lastLat), 32'd17);

    writeCube(0, 11'h3FF, 11'h380, 1'b1);
    applyStimulus(11'h380, 0);
    checkOutput("lit_c0_f", 32'(lastF), 32'd1);
    checkOutput("lit_c0_idx", 32'(lastIdx), 32'd0);
    checkOutput("lit_c0_lat", 32'(lastLat), 32'd2);
    applyStimulus(11'h780, 0);
    checkOutput("lit_c0_dc_f", 32'(lastF), 32'd1);
    applyStimulus(11'h381, 0);
    checkOutput("lit_c0_miss_f", 32'(lastF), 32'd0);
    checkOutput("lit_c0_miss_lat", 32'(lastLat), 32'd17);

    writeCube(0, 11'h000, 11'h000, 1'b0);
    writeCube(63, 11'h7FF, 11'h123, 1'b1);
    applyStimulus(11'h123, 0);
    checkOutput("lit_c63_idx", 32'(lastIdx), 32'd63);
    checkOutput("lit_c63_lat", 32'(lastLat), 32'd17);

    writeCube(63, 11'h000, 11'h000, 1'b0);
    writeCube(5, 11'h0F0, 11'h050, 1'b1);
    writeCube(6, 11'h00F, 11'h005, 1'b1);
    applyStimulus(11'h055, 0);
    checkOutput("lit_c5_idx", 32'(lastIdx), 32'd5);
    checkOutput("lit_c5_lat", 32'(lastLat), 32'd3);

    writeCube(5, 11'h000, 11'h000, 1'b0);
    writeCube(6, 11'h000, 11'h000, 1'b0);
    writeCube(2, 11'h700, 11'h100, 1'b1);
    writeCube(9, 11'h700, 11'h100, 1'b1);
    applyStimulus(11'h155, 0);
    checkOutput("lit_c2_idx", 32'(lastIdx), 32'd2);
    checkOutput("lit_c2_lat", 32'(lastLat), 32'd2);

    writeCube(2, 11'h000, 11'h000, 1'b0);
    writeCube(9, 11'h000, 11'h000, 1'b0);
    writeCube(30, 11'h000, 11'h5A5, 1'b1);
    applyStimulus(11'(($urandom)), 0);
    checkOutput("lit_const1_idx", 32'(lastIdx), 32'd30);
    checkOutput("lit_const1_lat", 32'(lastLat), 32'd9);

    applyStimulus(11'h7FF, 5);
    checkOutput("lit_hold_idx", 32'(lastIdx), 32'd30);
    applyStimulus(11'h7FF, 0);
    checkOutput("lit_dropped_write", 32'(lastIdx), 32'd30);

    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 6'd1;
    cfg_care = '0;
    cfg_val  = '0;
    cfg_en   = 1'b1;
    in_valid = 1'b1;
    in_vec   = 11'h7FF;
    #1;
    checkOutput("cfg_beats_in_ready", 32'(in_ready), 32'd0);
    checkOutput("cfg_beats_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    mCare[1] = '0;
    mVal[1]  = '0;
    mEn[1]   = 1'b1;
    @(negedge clk);
    checkOutput("vector_not_taken", 32'(in_ready), 32'd1);
    applyStimulus(11'h7FF, 0);
    checkOutput("lit_simul_idx", 32'(lastIdx), 32'd1);
    checkOutput("lit_simul_lat", 32'(lastLat), 32'd2);

    for (int round = 0; round < 4; round++) begin
      for (int w = 0; w < 12; w++) begin
        writeCube($urandom_range(0, NC - 1),
                  11'($urandom & $urandom & $urandom),
                  11'($urandom),
                  1'($urandom_range(0, 3) != 0));
      end
      for (int t = 0; t < 8; t++) begin
        applyStimulus(11'($urandom), $urandom_range(0, 2));
      end
    end

    writeCube(0, 11'h000, 11'h000, 1'b1);
    applyStimulus(11'h2AA, 0);
    checkOutput("lit_pre_rst_f", 32'(lastF), 32'd1);
    @(negedge clk);
    in_vec   = 11'h2AA;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_f", 32'(out_f), 32'd0);
    checkOutput("midrst_hit_idx", 32'(out_hit_idx), 32'd0);
    modelClear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(11'h2AA, 0);
    checkOutput("lit_cleared_f", 32'(lastF), 32'd0);
    checkOutput("lit_cleared_lat", 32'(lastLat), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
